// File: rtl/ariane_regfile_mp_if.sv
// Operand-side bus of the multi-port register file: read/write ports plus the
// bulk-clear handshake. The issue/commit side is the master, the regfile the slave.
interface ariane_regfile_mp_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_WORDS      = 32,
    parameter int NR_READ_PORTS  = 2,
    parameter int NR_WRITE_PORTS = 2
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);

    logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o;
    logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NR_WRITE_PORTS-1:0]                 we_i;
    logic                                      wready_o;
    logic                                      wconflict_o;
    logic                                      clear_i;
    logic                                      clear_busy_o;
    logic                                      clear_done_o;

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i, clear_i,
        input  rdata_o, wready_o, wconflict_o, clear_busy_o, clear_done_o
    );

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i, clear_i,
        output rdata_o, wready_o, wconflict_o, clear_busy_o, clear_done_o
    );
endinterface

// File: rtl/ariane_regfile_mp.sv
// Multi-port flip-flop register file with prioritised writes, collision flag,
// optional write-to-read bypass and a one-word-per-cycle bulk-clear engine.

// One combinational read lane: array lookup, bypass from the winning writer, zero word.
module ariane_regfile_mp_rport #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_WORDS      = 32,
    parameter int NR_WRITE_PORTS = 2,
    parameter int ADDR_WIDTH     = 5,
    parameter bit ZERO_REG_ZERO  = 1'b1,
    parameter bit BYPASS         = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0]                      raddr,
    input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]       mem,
    input  logic [NR_WRITE_PORTS-1:0]                  wacc,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  waddr,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata,
    output logic [DATA_WIDTH-1:0]                      rdata
);
    always_comb begin
        rdata = mem[raddr];
        // Ascending scan so the highest-index accepted writer is the one forwarded.
        if (BYPASS) begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (wacc[j] && (waddr[j] == raddr)) rdata = wdata[j];
            end
        end
        if (ZERO_REG_ZERO && (raddr == '0)) rdata = '0;
    end
endmodule

module ariane_regfile_mp #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_WORDS      = 32,
    parameter int NR_READ_PORTS  = 2,
    parameter int NR_WRITE_PORTS = 2,
    parameter bit ZERO_REG_ZERO  = 1'b1,
    parameter bit BYPASS         = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ariane_regfile_mp_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e                                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]                   cnt_q, cnt_d;
    logic                                    done_q, done_d;
    logic                                    wconflict_q, wconflict_d;
    logic                                    clr_en;
    logic                                    wready;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]    mem_q;
    logic [NR_WRITE_PORTS-1:0]               wacc;
    logic [NUM_WORDS-1:0]                    wen;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]    wval;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata;

    // Clear FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Clear FSM: next state. clear_i is only looked at in IDLE, so it cannot restart a sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        clr_en = 1'b0;
        wready = 1'b1;
        case (state_q)
            IDLE:  wready = 1'b1;
            CLEAR: begin
                clr_en = 1'b1;
                wready = 1'b0;
            end
        endcase
    end

    always_comb begin
        wacc = '0;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            wacc[j] = bus.we_i[j] && wready && !(ZERO_REG_ZERO && (bus.waddr_i[j] == '0));
        end
    end

    // Only accepted writes can collide; dropped ones never reach the array.
    always_comb begin
        wconflict_d = 1'b0;
        for (int i = 0; i < NR_WRITE_PORTS; i++) begin
            for (int j = i + 1; j < NR_WRITE_PORTS; j++) begin
                if (wacc[i] && wacc[j] && (bus.waddr_i[i] == bus.waddr_i[j])) wconflict_d = 1'b1;
            end
        end
    end

    // Per-word write decode; later ports overwrite earlier ones, giving highest-index priority.
    always_comb begin
        wen  = '0;
        wval = '0;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            if (wacc[j]) begin
                wen[bus.waddr_i[j]]  = 1'b1;
                wval[bus.waddr_i[j]] = bus.wdata_i[j];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q       <= '0;
            wconflict_q <= 1'b0;
        end else begin
            wconflict_q <= wconflict_d;
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (ZERO_REG_ZERO && (w == 0))                    mem_q[w] <= '0;
                else if (clr_en && (cnt_q == ADDR_WIDTH'(w)))     mem_q[w] <= '0;
                else if (wen[w])                                  mem_q[w] <= wval[w];
            end
        end
    end

    for (genvar k = 0; k < NR_READ_PORTS; k++) begin : g_rd
        ariane_regfile_mp_rport #(
            .DATA_WIDTH     (DATA_WIDTH),
            .NUM_WORDS      (NUM_WORDS),
            .NR_WRITE_PORTS (NR_WRITE_PORTS),
            .ADDR_WIDTH     (ADDR_WIDTH),
            .ZERO_REG_ZERO  (ZERO_REG_ZERO),
            .BYPASS         (BYPASS)
        ) u_rport (
            .raddr (bus.raddr_i[k]),
            .mem   (mem_q),
            .wacc  (wacc),
            .waddr (bus.waddr_i),
            .wdata (bus.wdata_i),
            .rdata (rdata[k])
        );
    end

    assign bus.rdata_o      = rdata;
    assign bus.wready_o     = wready;
    assign bus.wconflict_o  = wconflict_q;
    assign bus.clear_busy_o = clr_en;
    assign bus.clear_done_o = done_q;
endmodule

// File: tb/tb_ariane_regfile_mp.sv
module tb_ariane_regfile_mp;
    localparam int AW = 5;

    localparam int K_RDA   = 0;
    localparam int K_RDB   = 1;
    localparam int K_CONF  = 2;
    localparam int K_RDY   = 3;
    localparam int K_BUSY  = 4;
    localparam int K_DONE  = 5;
    localparam int K_CONFB = 6;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [63:0] exp;
        string       name;
    } sb_item_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    sb_item_t    sb[$];
    sb_item_t    it;
    logic [63:0] act;

    ariane_regfile_mp_if ifa ();
    ariane_regfile_mp_if ifb ();

    ariane_regfile_mp dut_a (.clk_i(clk_i), .rst_i(rst_i), .bus(ifa));
    ariane_regfile_mp #(.BYPASS(1'b0)) dut_b (.clk_i(clk_i), .rst_i(rst_i), .bus(ifb));

    assign ifb.raddr_i = ifa.raddr_i;
    assign ifb.waddr_i = ifa.waddr_i;
    assign ifb.wdata_i = ifa.wdata_i;
    assign ifb.we_i    = ifa.we_i;
    assign ifb.clear_i = ifa.clear_i;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [63:0] observe(input int kind, input int port);
        case (kind)
            K_RDA:   return ifa.rdata_o[port];
            K_RDB:   return ifb.rdata_o[port];
            K_CONF:  return {63'b0, ifa.wconflict_o};
            K_RDY:   return {63'b0, ifa.wready_o};
            K_BUSY:  return {63'b0, ifa.clear_busy_o};
            K_DONE:  return {63'b0, ifa.clear_done_o};
            K_CONFB: return {63'b0, ifb.wconflict_o};
            default: return 64'hx;
        endcase
    endfunction

    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it  = sb.pop_front();
            act = observe(it.kind, it.port);
            total++;
            if (it.cyc != cyc || act !== it.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", it.name, cyc, act, it.exp);
            end
        end
    end

    task automatic chk(input int kind, input int port, input logic [63:0] e, input string nm);
        sb_item_t s;
        s.cyc  = cyc;
        s.kind = kind;
        s.port = port;
        s.exp  = e;
        s.name = nm;
        sb.push_back(s);
    endtask

    task automatic now_chk(input int kind, input int port, input logic [63:0] e, input string nm);
        logic [63:0] v;
        #1;
        v = observe(kind, port);
        total++;
        if (v !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, v, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [63:0] d, input logic e);
        ifa.waddr_i[p] = a;
        ifa.wdata_i[p] = d;
        ifa.we_i[p]    = e;
    endtask

    function automatic logic [63:0] fill_val(input int w);
        return (w == 0) ? 64'h0 : 64'h1000 + 64'(w);
    endfunction

    task automatic fill_all();
        for (int w = 0; w < 32; w += 2) begin
            set_wr(0, AW'(w), 64'h1000 + 64'(w), 1'b1);
            set_wr(1, AW'(w + 1), 64'h1000 + 64'(w + 1), 1'b1);
            tick();
        end
        ifa.we_i = '0;
    endtask

    task automatic read_all_zero(input string nm);
        for (int a = 0; a < 32; a += 2) begin
            ifa.raddr_i[0] = AW'(a);
            ifa.raddr_i[1] = AW'(a + 1);
            chk(K_RDA, 0, 64'h0, nm);
            chk(K_RDA, 1, 64'h0, nm);
            chk(K_DONE, 0, 64'h0, {nm, "_done"});
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        ifa.raddr_i = '0;
        ifa.waddr_i = '0;
        ifa.wdata_i = '0;
        ifa.we_i    = '0;
        ifa.clear_i = 1'b0;
        tick();
        tick();

        ifa.raddr_i[0] = AW'(5);
        chk(K_RDA, 0, 64'h0, "rst_rdata");
        chk(K_RDY, 0, 64'h1, "rst_wready");
        chk(K_BUSY, 0, 64'h0, "rst_busy");
        chk(K_CONF, 0, 64'h0, "rst_conf");
        chk(K_DONE, 0, 64'h0, "rst_done");
        tick();
        rst_i = 1'b0;
        read_all_zero("init_zero");

        set_wr(0, AW'(5), 64'hA5A5, 1'b1);
        set_wr(1, AW'(7), 64'h1234, 1'b1);
        tick();
        ifa.we_i = '0;
        ifa.raddr_i[0] = AW'(5);
        ifa.raddr_i[1] = AW'(7);
        chk(K_RDA, 0, 64'hA5A5, "wr_p0");
        chk(K_RDA, 1, 64'h1234, "wr_p1");
        chk(K_RDB, 0, 64'hA5A5, "wr_p0_b");
        chk(K_CONF, 0, 64'h0, "wr_noconf");
        now_chk(K_RDA, 0, 64'hA5A5, "wr_p0_now");
        now_chk(K_RDA, 1, 64'h1234, "wr_p1_now");
        tick();

        set_wr(0, AW'(3), 64'h11, 1'b1);
        set_wr(1, AW'(3), 64'h22, 1'b1);
        ifa.raddr_i[0] = AW'(3);
        chk(K_RDA, 0, 64'h22, "coll_bypass");
        chk(K_RDB, 0, 64'h0, "coll_nobypass");
        chk(K_CONF, 0, 64'h0, "coll_conf_pre");
        now_chk(K_RDA, 0, 64'h22, "coll_bypass_now");
        tick();
        ifa.we_i = '0;
        chk(K_RDA, 0, 64'h22, "coll_winner");
        chk(K_RDB, 0, 64'h22, "coll_winner_b");
        chk(K_CONF, 0, 64'h1, "coll_conf");
        chk(K_CONFB, 0, 64'h1, "coll_conf_b");
        now_chk(K_CONF, 0, 64'h1, "coll_conf_now");
        tick();
        chk(K_CONF, 0, 64'h0, "coll_conf_drop");
        tick();

        set_wr(0, AW'(9), 64'hBEEF, 1'b1);
        ifa.raddr_i[0] = AW'(9);
        chk(K_RDA, 0, 64'hBEEF, "byp_same");
        chk(K_RDB, 0, 64'h0, "nobyp_same");
        now_chk(K_RDA, 0, 64'hBEEF, "byp_same_now");
        now_chk(K_RDB, 0, 64'h0, "nobyp_same_now");
        tick();
        ifa.we_i = '0;
        chk(K_RDA, 0, 64'hBEEF, "byp_next");
        chk(K_RDB, 0, 64'hBEEF, "nobyp_next");
        tick();

        set_wr(0, AW'(0), 64'hAAAA, 1'b1);
        set_wr(1, AW'(0), 64'hFFFF, 1'b1);
        ifa.raddr_i[0] = AW'(0);
        ifa.raddr_i[1] = AW'(0);
        chk(K_RDA, 0, 64'h0, "zero_byp_p0");
        chk(K_RDA, 1, 64'h0, "zero_byp_p1");
        chk(K_RDB, 0, 64'h0, "zero_nobyp");
        now_chk(K_RDA, 1, 64'h0, "zero_byp_now");
        tick();
        ifa.we_i = '0;
        chk(K_RDA, 0, 64'h0, "zero_next");
        chk(K_CONF, 0, 64'h0, "zero_noconf");
        tick();

        fill_all();
        ifa.raddr_i[0] = AW'(31);
        ifa.raddr_i[1] = AW'(17);
        chk(K_RDA, 0, 64'h101F, "fill_31");
        chk(K_RDA, 1, 64'h1011, "fill_17");
        ifa.clear_i = 1'b1;
        chk(K_BUSY, 0, 64'h0, "clr_req_idle");
        chk(K_RDY, 0, 64'h1, "clr_req_rdy");
        tick();
        ifa.clear_i = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            ifa.raddr_i[0] = AW'(k - 1);
            ifa.raddr_i[1] = (k >= 2) ? AW'(k - 2) : AW'(0);
            if (k == 6) ifa.raddr_i[1] = AW'(2);
            if (k == 5) set_wr(0, AW'(2), 64'hDEAD, 1'b1);
            else        ifa.we_i = '0;
            ifa.clear_i = (k == 10);
            chk(K_BUSY, 0, 64'h1, "clr_busy");
            chk(K_RDY, 0, 64'h0, "clr_wready");
            chk(K_DONE, 0, 64'h0, "clr_nodone");
            chk(K_RDA, 0, fill_val(k - 1), "clr_uncleared");
            chk(K_RDA, 1, 64'h0, "clr_cleared");
            tick();
        end
        ifa.we_i    = '0;
        ifa.clear_i = 1'b0;
        chk(K_BUSY, 0, 64'h0, "clr_end_busy");
        chk(K_RDY, 0, 64'h1, "clr_end_rdy");
        chk(K_DONE, 0, 64'h1, "clr_done_pulse");
        now_chk(K_DONE, 0, 64'h1, "clr_done_now");
        tick();
        chk(K_DONE, 0, 64'h0, "clr_done_once");
        chk(K_BUSY, 0, 64'h0, "clr_no_restart");
        tick();
        read_all_zero("clr_zero");

        fill_all();
        ifa.clear_i = 1'b1;
        tick();
        ifa.clear_i = 1'b0;
        for (int k = 1; k < 10; k++) begin
            chk(K_BUSY, 0, 64'h1, "abort_busy");
            tick();
        end
        rst_i = 1'b1;
        ifa.raddr_i[0] = AW'(31);
        chk(K_BUSY, 0, 64'h0, "abort_rst_busy");
        chk(K_RDY, 0, 64'h1, "abort_rst_rdy");
        chk(K_DONE, 0, 64'h0, "abort_rst_done");
        chk(K_RDA, 0, 64'h0, "abort_rst_mem");
        tick();
        rst_i = 1'b0;
        read_all_zero("abort_zero");
        for (int k = 0; k < 10; k++) begin
            chk(K_DONE, 0, 64'h0, "abort_nodone");
            chk(K_BUSY, 0, 64'h0, "abort_idle");
            tick();
        end

        @(negedge clk_i);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad == 0) $display("PASS");
        else          $display("FAIL bad=%0d", bad);
        $finish;
    end
endmodule
